// File: rtl/mandel_job_scheduler_pkg.sv
// Shared widths, scheduler state encoding and framebuffer address packing
// for the Mandelbrot job scheduler.
package mandel_job_scheduler_pkg;

    localparam int ADDR_W = 20;
    localparam int AXIS_W = 10;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } sched_state_t;

    // Framebuffer address is column-major packed: {col, row}
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [AXIS_W-1:0] col,
                                                    input logic [AXIS_W-1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/mandel_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starts one
// past the most recent grant; pointer only moves when a grant is issued.
module mandel_job_scheduler_rr_arbiter
    import mandel_job_scheduler_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic             found;

    // Two passes: lanes above the pointer first, then wrap around to the rest
    always_comb begin
        gnt      = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && en && req[i] && (i > int'(ptr_reg))) begin
                found    = 1'b1;
                gnt[i]   = 1'b1;
                ptr_next = PTR_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && en && req[i] && (i <= int'(ptr_reg))) begin
                found    = 1'b1;
                gnt[i]   = 1'b1;
                ptr_next = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ptr_reg <= PTR_W'(N - 1);
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/mandel_job_scheduler.sv
// Frame sequencer: scans pixels column-major, hands one job per cycle to the
// lowest free lane, collects lane results round-robin into a one-deep write register.
module mandel_job_scheduler
    import mandel_job_scheduler_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int COLS    = 640,
    parameter int ROWS    = 480,
    parameter int COORD_W = 32,
    parameter int ITER_W  = 8
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iStart,
    input  logic [COORD_W-1:0]      iRe0,
    input  logic [COORD_W-1:0]      iIm0,
    input  logic [COORD_W-1:0]      iStep,
    output logic                    oBusy,
    output logic                    oFrameDone,
    output logic [LANES-1:0]        oJob_sel,
    output logic [COORD_W-1:0]      oJob_re,
    output logic [COORD_W-1:0]      oJob_im,
    input  logic [LANES-1:0]        iRes_valid,
    input  logic [LANES*ITER_W-1:0] iRes_iter,
    output logic [LANES-1:0]        oRes_ack,
    output logic                    oWr_en,
    output logic [ADDR_W-1:0]       oWr_addr,
    output logic [DATA_W-1:0]       oWr_data,
    input  logic                    iWr_ready
);

    localparam logic [AXIS_W-1:0] COL_LAST = AXIS_W'(COLS - 1);
    localparam logic [AXIS_W-1:0] ROW_LAST = AXIS_W'(ROWS - 1);

    sched_state_t        state_reg;
    logic [AXIS_W-1:0]   col_reg;
    logic [AXIS_W-1:0]   row_reg;
    logic [COORD_W-1:0]  cur_re_reg;
    logic [COORD_W-1:0]  cur_im_reg;
    logic [COORD_W-1:0]  im0_reg;
    logic [COORD_W-1:0]  step_reg;
    logic [LANES-1:0]    lane_busy_reg;
    logic                wr_en_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [DATA_W-1:0]   wr_data_reg;

    logic [LANES-1:0]    free_lanes;
    logic [LANES-1:0]    job_sel;
    logic [LANES-1:0]    res_ack;
    logic                arb_en;
    logic                ack_any;
    logic                last_pixel;
    logic [ADDR_W-1:0]   ack_addr;
    logic [ITER_W-1:0]   ack_iter;

    logic [LANES-1:0][ADDR_W-1:0] tag_masked;
    logic [LANES-1:0][ITER_W-1:0] iter_masked;

    // Isolate the lowest free lane with the two's-complement trick
    assign free_lanes = ~lane_busy_reg;
    assign job_sel    = (state_reg == ST_DISPATCH) ? (free_lanes & (~free_lanes + LANES'(1))) : '0;
    assign last_pixel = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

    // Results are only taken when the write register is empty or emptying now
    assign arb_en  = !wr_en_reg || iWr_ready;
    assign ack_any = |res_ack;

    mandel_job_scheduler_rr_arbiter #(
        .N (LANES)
    ) u_arb (
        .iCLK (iCLK),
        .iRST (iRST),
        .req  (iRes_valid & lane_busy_reg),
        .en   (arb_en),
        .gnt  (res_ack)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ADDR_W-1:0] tag_reg;

            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    tag_reg <= '0;
                end else if (job_sel[gi]) begin
                    tag_reg <= pack_addr(col_reg, row_reg);
                end
            end

            assign tag_masked[gi]  = res_ack[gi] ? tag_reg : '0;
            assign iter_masked[gi] = res_ack[gi] ? iRes_iter[gi*ITER_W +: ITER_W] : '0;
        end
    endgenerate

    always_comb begin
        ack_addr = '0;
        ack_iter = '0;
        for (int i = 0; i < LANES; i++) begin
            ack_addr = ack_addr | tag_masked[i];
            ack_iter = ack_iter | iter_masked[i];
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg     <= ST_IDLE;
            col_reg       <= '0;
            row_reg       <= '0;
            cur_re_reg    <= '0;
            cur_im_reg    <= '0;
            im0_reg       <= '0;
            step_reg      <= '0;
            lane_busy_reg <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            lane_busy_reg <= (lane_busy_reg & ~res_ack) | job_sel;

            if (ack_any) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= ack_addr;
                wr_data_reg <= DATA_W'(ack_iter);
            end else if (iWr_ready) begin
                wr_en_reg   <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (iStart) begin
                        state_reg  <= ST_DISPATCH;
                        cur_re_reg <= iRe0;
                        cur_im_reg <= iIm0;
                        im0_reg    <= iIm0;
                        step_reg   <= iStep;
                        col_reg    <= '0;
                        row_reg    <= '0;
                    end
                end
                ST_DISPATCH: begin
                    if (|job_sel) begin
                        if (last_pixel) begin
                            state_reg <= ST_DRAIN;
                        end else if (row_reg == ROW_LAST) begin
                            row_reg    <= '0;
                            cur_im_reg <= im0_reg;
                            col_reg    <= col_reg + AXIS_W'(1);
                            cur_re_reg <= cur_re_reg + step_reg;
                        end else begin
                            row_reg    <= row_reg + AXIS_W'(1);
                            cur_im_reg <= cur_im_reg + step_reg;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((lane_busy_reg == '0) && !wr_en_reg) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign oBusy      = (state_reg != ST_IDLE);
    assign oFrameDone = (state_reg == ST_DONE);
    assign oJob_sel   = job_sel;
    assign oJob_re    = cur_re_reg;
    assign oJob_im    = cur_im_reg;
    assign oRes_ack   = res_ack;
    assign oWr_en     = wr_en_reg;
    assign oWr_addr   = wr_addr_reg;
    assign oWr_data   = wr_data_reg;

endmodule

// File: tb/tb_mandel_job_scheduler.sv
// Randomized bench: lane models plus a pixel-level reference of dispatch order,
// coordinates, round-robin result collection and the framebuffer write stream.
module tb_mandel_job_scheduler;

    localparam int LANES   = 2;
    localparam int COLS    = 4;
    localparam int ROWS    = 3;
    localparam int COORD_W = 32;
    localparam int ITER_W  = 8;
    localparam int TOTAL   = COLS * ROWS;

    logic iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    logic                    iRST, iStart, iWr_ready;
    logic [COORD_W-1:0]      iRe0, iIm0, iStep;
    logic                    oBusy, oFrameDone, oWr_en;
    logic [LANES-1:0]        oJob_sel, oRes_ack, iRes_valid;
    logic [COORD_W-1:0]      oJob_re, oJob_im;
    logic [LANES*ITER_W-1:0] iRes_iter;
    logic [19:0]             oWr_addr;
    logic [15:0]             oWr_data;

    // Single-lane instance whose lane never answers
    logic        s_rst, s_start, s_busy, s_done, s_wr_en, s_wr_ready;
    logic [0:0]  s_sel, s_ack, s_res_valid;
    logic [7:0]  s_res_iter;
    logic [31:0] s_re, s_im;
    logic [19:0] s_wr_addr;
    logic [15:0] s_wr_data;

    mandel_job_scheduler #(.LANES(LANES), .COLS(COLS), .ROWS(ROWS),
                           .COORD_W(COORD_W), .ITER_W(ITER_W)) u_dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart),
        .iRe0(iRe0), .iIm0(iIm0), .iStep(iStep),
        .oBusy(oBusy), .oFrameDone(oFrameDone),
        .oJob_sel(oJob_sel), .oJob_re(oJob_re), .oJob_im(oJob_im),
        .iRes_valid(iRes_valid), .iRes_iter(iRes_iter), .oRes_ack(oRes_ack),
        .oWr_en(oWr_en), .oWr_addr(oWr_addr), .oWr_data(oWr_data),
        .iWr_ready(iWr_ready)
    );

    mandel_job_scheduler #(.LANES(1), .COLS(COLS), .ROWS(ROWS),
                           .COORD_W(32), .ITER_W(8)) u_dut1 (
        .iCLK(iCLK), .iRST(s_rst), .iStart(s_start),
        .iRe0(iRe0), .iIm0(iIm0), .iStep(iStep),
        .oBusy(s_busy), .oFrameDone(s_done),
        .oJob_sel(s_sel), .oJob_re(s_re), .oJob_im(s_im),
        .iRes_valid(s_res_valid), .iRes_iter(s_res_iter), .oRes_ack(s_ack),
        .oWr_en(s_wr_en), .oWr_addr(s_wr_addr), .oWr_data(s_wr_data),
        .iWr_ready(s_wr_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: frame phase 0 idle, 1 issuing, 2 draining, 3 done
    int          phase, issued, last_grant, cyc;
    logic [31:0] m_re0, m_im0, m_step;
    bit          has_job [LANES];
    int          job_pix [LANES];
    int          rdy_cyc [LANES];
    logic [7:0]  lane_iter [LANES];
    bit          slot_v;
    logic [19:0] slot_addr;
    logic [15:0] slot_data;
    int          exp_iter [TOTAL];
    int          wr_count [TOTAL];
    int          writes, done_seen;
    bit          just_reset;
    logic [31:0] job_re_log[$];
    logic [31:0] job_im_log[$];

    int dmin, dmax, ready_pct, hold_low;
    bit spurious;
    bit mon1;
    int s_sel_pulses, s_done_seen;

    task automatic model_reset();
        phase = 0; issued = 0; last_grant = LANES - 1; slot_v = 1'b0;
        just_reset = 1'b1;
        for (int i = 0; i < LANES; i++) has_job[i] = 1'b0;
    endtask

    task automatic observe();
        logic [LANES-1:0] exp_sel, exp_ack;
        logic [31:0]      e_re, e_im;
        int               g, ph, sel_lane, col, row, pix;
        bit               drain_ok;

        if (mon1) begin
            if (s_sel != 1'b0) s_sel_pulses++;
            if (s_done) s_done_seen++;
        end
        if (iRST) begin
            model_reset();
            return;
        end

        ph = phase;
        chk("busy", oBusy, ph != 0);
        chk("frame_done", oFrameDone, ph == 3);
        if (oFrameDone) begin
            done_seen++;
            chk("done_after_all_writes", writes, TOTAL);
        end

        exp_sel = '0; sel_lane = -1;
        if (ph == 1 && issued < TOTAL)
            for (int i = LANES - 1; i >= 0; i--)
                if (!has_job[i]) begin exp_sel = LANES'(1) << i; sel_lane = i; end
        chk("job_sel", oJob_sel, exp_sel);
        if (sel_lane >= 0) begin
            col = issued / ROWS; row = issued % ROWS;
            e_re = m_re0 + 32'(col) * m_step;
            e_im = m_im0 + 32'(row) * m_step;
            chk("job_re", oJob_re, e_re);
            chk("job_im", oJob_im, e_im);
            job_re_log.push_back(oJob_re);
            job_im_log.push_back(oJob_im);
        end

        g = -1;
        if (!(slot_v && !iWr_ready))
            for (int k = 1; k <= LANES; k++) begin
                int idx;
                idx = (last_grant + k) % LANES;
                if (g < 0 && iRes_valid[idx] && has_job[idx]) g = idx;
            end
        exp_ack = (g >= 0) ? (LANES'(1) << g) : '0;
        chk("res_ack", oRes_ack, exp_ack);

        chk("wr_en", oWr_en, slot_v);
        if (slot_v) begin
            chk("wr_addr", oWr_addr, slot_addr);
            chk("wr_data", oWr_data, slot_data);
        end
        if (just_reset) begin
            chk("rst_job_re", oJob_re, 0);
            chk("rst_job_im", oJob_im, 0);
            chk("rst_wr_addr", oWr_addr, 0);
            chk("rst_wr_data", oWr_data, 0);
            chk("rst_res_ack", oRes_ack, 0);
            just_reset = 1'b0;
        end

        drain_ok = (ph == 2) && !slot_v;
        for (int i = 0; i < LANES; i++) if (has_job[i]) drain_ok = 1'b0;

        if (oWr_en && iWr_ready) begin
            col = int'(oWr_addr[19:10]); row = int'(oWr_addr[9:0]);
            $display("t=%0t write col=%0d row=%0d data=%0d", $time, col, row, oWr_data);
            writes++;
            if (col < COLS && row < ROWS) begin
                pix = col * ROWS + row;
                wr_count[pix]++;
                chk("wr_data_for_pixel", oWr_data, exp_iter[pix]);
            end else begin
                chk("wr_addr_in_frame", 0, 1);
            end
        end
        if (slot_v && iWr_ready) slot_v = 1'b0;

        if (g >= 0) begin
            slot_v     = 1'b1;
            slot_addr  = {10'(job_pix[g] / ROWS), 10'(job_pix[g] % ROWS)};
            slot_data  = 16'(lane_iter[g]);
            last_grant = g;
            has_job[g] = 1'b0;
        end

        if (sel_lane >= 0) begin
            has_job[sel_lane]   = 1'b1;
            job_pix[sel_lane]   = issued;
            rdy_cyc[sel_lane]   = cyc + int'($urandom_range(dmin, dmax));
            lane_iter[sel_lane] = 8'($urandom);
            exp_iter[issued]    = int'(lane_iter[sel_lane]);
            issued++;
            if (issued == TOTAL) phase = 2;
        end

        if (ph == 0 && iStart) begin
            phase = 1; issued = 0; writes = 0; done_seen = 0;
            m_re0 = iRe0; m_im0 = iIm0; m_step = iStep;
            for (int p = 0; p < TOTAL; p++) wr_count[p] = 0;
            job_re_log.delete();
            job_im_log.delete();
        end
        if (drain_ok) phase = 3;
        if (ph == 3) phase = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < LANES; i++) begin
            if (has_job[i] && cyc >= rdy_cyc[i]) begin
                iRes_valid[i] = 1'b1;
                iRes_iter[i*ITER_W +: ITER_W] = lane_iter[i];
            end else begin
                iRes_valid[i] = spurious && !has_job[i] && ($urandom_range(0, 1) == 1);
                iRes_iter[i*ITER_W +: ITER_W] = ITER_W'($urandom);
            end
        end
        if (iRST) iRes_valid = '0;
        if (hold_low > 0) begin
            iWr_ready = 1'b0;
            hold_low--;
        end else begin
            iWr_ready = ($urandom_range(0, 99) < ready_pct);
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
        observe();
        @(posedge iCLK);
        cyc++;
        #1;
        drive();
    endtask

    task automatic start_frame(input logic [31:0] re0, input logic [31:0] im0, input logic [31:0] step);
        iRe0 = re0; iIm0 = im0; iStep = step;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic finish_frame(input int budget);
        int n;
        n = 0;
        while (phase != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("frame_completes_in_budget", phase == 0, 1);
        if (phase == 0) begin
            chk("write_count", writes, TOTAL);
            chk("done_pulses", done_seen, 1);
            for (int p = 0; p < TOTAL; p++) chk("pixel_written_once", wr_count[p], 1);
        end else begin
            iRST = 1'b1; tick(); iRST = 1'b0; tick();
        end
    endtask

    task automatic run_frame(input logic [31:0] re0, input logic [31:0] im0, input logic [31:0] step);
        start_frame(re0, im0, step);
        finish_frame(3000);
    endtask

    initial begin
        iRST = 1'b1; iStart = 1'b0; iWr_ready = 1'b1;
        iRe0 = '0; iIm0 = '0; iStep = '0;
        iRes_valid = '0; iRes_iter = '0;
        s_rst = 1'b1; s_start = 1'b0; s_res_valid = '0; s_res_iter = '0; s_wr_ready = 1'b1;
        cyc = 0; dmin = 2; dmax = 2; ready_pct = 100; hold_low = 0; spurious = 1'b0;
        mon1 = 1'b0; s_sel_pulses = 0; s_done_seen = 0;
        writes = 0; done_seen = 0;
        model_reset();

        repeat (3) tick();
        iRST = 1'b0;
        tick();
        tick();

        // Basic frame: unit step, lanes answer two cycles after the job
        run_frame(32'd0, 32'd0, 32'd1);
        if (job_re_log.size() >= 4) begin
            chk("job3_re", job_re_log[2], 0);
            chk("job3_im", job_im_log[2], 2);
            chk("job4_re", job_re_log[3], 1);
            chk("job4_im", job_im_log[3], 0);
        end else begin
            chk("job_log_size", job_re_log.size(), TOTAL);
        end

        // Real axis wraps past the most positive coordinate
        run_frame(32'h7FFF_FFFF, 32'd0, 32'd1);
        if (job_re_log.size() >= 4) chk("wrap_col1_re", job_re_log[3], 32'h8000_0000);
        else chk("job_log_size", job_re_log.size(), TOTAL);

        // Backpressure: framebuffer stalls ten cycles with a write pending
        dmin = 1; dmax = 1;
        start_frame(32'd10, 32'd20, 32'd3);
        for (int n = 0; n < 50 && !slot_v; n++) tick();
        iWr_ready = 1'b0;
        hold_low = 9;
        finish_frame(3000);

        // Start pulse mid-frame must not disturb the scan
        dmin = 2; dmax = 4;
        start_frame(32'd0, 32'd0, 32'd1);
        repeat (3) tick();
        iRe0 = 32'h1234_5678; iIm0 = 32'h0BAD_F00D; iStep = 32'd7;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        finish_frame(3000);
        if (job_re_log.size() >= 4) chk("midstart_job4_re", job_re_log[3], 1);
        else chk("job_log_size", job_re_log.size(), TOTAL);

        // Reset during a frame, then a full clean frame
        start_frame(32'd5, 32'd6, 32'd2);
        repeat (4) tick();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        tick();
        chk("post_reset_busy", oBusy, 0);
        chk("post_reset_sel", oJob_sel, 0);
        chk("post_reset_wr_en", oWr_en, 0);
        run_frame(32'd5, 32'd6, 32'd2);

        // Randomized frames with spurious valids and random backpressure
        spurious = 1'b1;
        for (int f = 0; f < 6; f++) begin
            dmin = 1;
            dmax = int'($urandom_range(1, 6));
            ready_pct = int'($urandom_range(40, 100));
            run_frame($urandom, $urandom, $urandom);
        end
        spurious = 1'b0; ready_pct = 100;

        // Single lane that never replies: one job, then a permanent stall
        s_rst = 1'b0;
        tick();
        mon1 = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (20) tick();
        chk("one_lane_job_pulses", s_sel_pulses, 1);
        chk("one_lane_busy", s_busy, 1);
        chk("one_lane_no_done", s_done_seen, 0);
        chk("one_lane_no_write", s_wr_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
